// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: operand width and 3-bit operation codes used by the
// arbiter and by the combinational ALU it feeds.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU; all arithmetic wraps modulo 2^32.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        ctrl,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (ctrl)
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      // shift amounts of 32 or more clear the result
      OP_SLL:  y = a << b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_ADDI: y = a + b;
      OP_SRAI: y = $signed(a) >>> b[4:0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU; one operation in
// flight, MUL occupies MUL_LAT execute cycles, results held until taken.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_data1_i,
  input  logic [DATA_W-1:0] req0_data2_i,
  input  logic [2:0]        req0_ctrl_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_data1_i,
  input  logic [DATA_W-1:0] req1_data2_i,
  input  logic [2:0]        req1_ctrl_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic              res_src_o,
  output logic              busy_o
);

  // state    | meaning
  // S_IDLE   | waiting for a request, grant issued combinationally
  // S_EXEC   | operands registered, counting down execute cycles
  // S_RESULT | result held on res_data_o until res_ready_i
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESULT} state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              rr_prio;
  logic [DATA_W-1:0] op_a, op_b, alu_y, res_data;
  logic [2:0]        op_ctrl, sel_ctrl;
  logic              src;
  logic              win0, win1, grant;

  // rr_prio names the requester that wins a tie
  assign win0  = req0_valid_i && (!req1_valid_i || !rr_prio);
  assign win1  = req1_valid_i && (!req0_valid_i ||  rr_prio);
  assign grant = (state == S_IDLE) && !rst_i && (req0_valid_i || req1_valid_i);
  assign sel_ctrl = win1 ? req1_ctrl_i : req0_ctrl_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (grant) state_nxt = S_EXEC;
      S_EXEC:   if (cnt == 4'd0) state_nxt = S_RESULT;
      S_RESULT: if (res_ready_i) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready_o = grant && win0;
    req1_ready_o = grant && win1;
    res_valid_o  = (state == S_RESULT);
    busy_o       = (state != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      rr_prio  <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_ctrl  <= '0;
      src      <= 1'b0;
      res_data <= '0;
    end else if (grant) begin
      op_a    <= win1 ? req1_data1_i : req0_data1_i;
      op_b    <= win1 ? req1_data2_i : req0_data2_i;
      op_ctrl <= sel_ctrl;
      src     <= win1;
      rr_prio <= !win1;
      cnt     <= (sel_ctrl == OP_MUL) ? MUL_CNT : 4'd0;
    end else if (state == S_EXEC) begin
      if (cnt != 4'd0) cnt      <= cnt - 4'd1;
      else             res_data <= alu_y;
    end
  end

  assign res_data_o = res_data;
  assign res_src_o  = src;

  alu_arbiter_alu u_alu (
    .a    (op_a),
    .b    (op_b),
    .ctrl (op_ctrl),
    .y    (alu_y)
  );

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3: execute cycles occupied by a MUL operation (legal range 1..15).
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports reqN_valid_i  input  1  request N presents an operation (N = 0, 1).
REQ-005 SHALL have ports reqN_ready_o  output  1  request N accepted this cycle.
REQ-006 SHALL have ports reqN_data1_i, reqN_data2_i  input  32 each  operands, signed.
REQ-007 SHALL have ports reqN_ctrl_i  input  3  operation code.
REQ-008 SHALL have port res_valid_o  output  1  result available.
REQ-009 SHALL have port res_ready_i  input  1  consumer takes the result.
REQ-010 SHALL have port res_data_o  output  32  result value.
REQ-011 SHALL have port res_src_o  output  1  index of the requester that owns the result.
REQ-012 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESULT; one operation in flight at most.
REQ-014 In IDLE, any reqN_valid_i SHALL produce a grant that same cycle; reqN_ready_o high only for the winner, only in IDLE; both ready outputs low in EXEC and RESULT.
REQ-015 Only one requester valid: it wins. Both valid: the requester not granted last wins (round-robin); after reset, requester 0 wins the first tie.
REQ-016 The round-robin pointer SHALL update only on a grant.
REQ-017 On grant, operands, ctrl and source index SHALL be registered; FSM -> EXEC with counter = MUL_LAT-1 for MUL (101), 0 for all other codes.
REQ-018 In EXEC, counter nonzero: decrement, stay. Counter zero: register the datapath output into res_data_o; FSM -> RESULT.
REQ-019 Datapath ops: 000 AND, 001 XOR, 010 SLL by full data2, 011 ADD, 100 SUB, 101 MUL (low 32 bits), 110 ADDI (add), 111 SRAI arithmetic shift by data2[4:0]; wrap-around modulo 2^32, no overflow flag.
REQ-020 In RESULT, res_valid_o SHALL be high; res_data_o and res_src_o SHALL remain stable until res_valid_o & res_ready_i, then FSM -> IDLE.
REQ-021 Latency, grant edge to res_valid_o: 2 cycles for non-MUL, 1+MUL_LAT cycles for MUL; earliest next grant is the cycle after the result handshake.
REQ-022 Input changes during EXEC/RESULT SHALL not affect the in-flight operation.
REQ-023 res_ready_i held high before RESULT SHALL not produce a handshake; handshake requires res_valid_o.

Reset
REQ-024 rst_i high SHALL force IDLE, res_valid_o=0, res_data_o=0, res_src_o=0, busy_o=0, counter=0, round-robin pointer favouring requester 0, at the next edge, overriding any grant or handshake.
REQ-025 Reset in EXEC or RESULT SHALL discard the in-flight operation with no result delivered.
REQ-026 reqN_ready_o SHALL be low while rst_i is high.

Structure
REQ-027 The 3-bit operation-code constants SHALL live in the shared ALU definitions package/header, used by this block and the ALU.
REQ-028 The datapath SHALL be the existing combinational ALU module, instantiated once and fed from the registered operands; there are no other sub-modules.
REQ-029 FSM state encoding SHALL be local to this block.

Verification
REQ-030 ADD: req0 ADD 5,7 alone, granted at cycle T -> res_valid_o at T+2, res_data_o=12, res_src_o=0.
REQ-031 MUL, MUL_LAT=3: req1 MUL 6,-3 -> ready1 at T, res_valid_o at T+4, res_data_o=0xFFFFFFEE (-18), res_src_o=1.
REQ-032 Both requesters continuously valid after reset, res_ready_i=1: grants 0,1,0,1; res_src_o alternates accordingly.
REQ-033 Backpressure: SRAI -16,2 with res_ready_i=0 for 5 cycles -> res_valid_o stays high, res_data_o=0xFFFFFFFC constant, no new ready; release -> IDLE next cycle.
REQ-034 Reset mid-operation: rst_i pulsed during MUL EXEC -> next cycle IDLE, busy_o=0, no res_valid_o; then a tie grants requester 0.
REQ-035 Wrap-around: ADD 0x7FFFFFFF,1 -> 0x80000000; SLL 1,33 -> 0.
